instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the segmented processor: owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Honours stall requests from the hazard unit and redirects (taken branch/jump) from EX. Halts fetch on an out-of-range PC until redirected.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words. The legal byte range is 0 .. IMEM_WORDS*4-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard unit: hold the PC and the IF/ID register.
- redirect_valid  input  1  EX: taken branch/jump this cycle.
- redirect_pc  input  32  target byte address.
- imem_addr  output  32  byte address to instruction memory. Combinational, equal to pc_q.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_pc  output  32  PC of the IF/ID instruction.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- if_id_instr  output  32  instruction word, or NOP 32'h0000_0013 when the slot is a bubble or fault.
- if_id_fault  output  1  the IF/ID slot came from an out-of-range PC.
- perf_fetched  output  32  count of valid instructions fetched (see Configuration).
- perf_bubbles  output  32  count of bubbles inserted (see Configuration).

## Operation
- State machine with two states:
  - RUN: normal fetch.
  - HALT: PC out of range; fetch is frozen.
- Out of range means pc_q >= IMEM_WORDS*4, compared as unsigned 32-bit values.
- Each rising edge is evaluated in this priority order:
  1. rst: pc_q=RESET_PC, state=RUN, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP, if_id_fault=0, both counters=0.
  2. redirect_valid:
     - pc_q={redirect_pc[31:2],2'b00}; state=RUN.
     - IF/ID is flushed: valid=0, instr=NOP, fault=0. pc/pc_plus4 are don't-care and hold their old values.
     - perf_bubbles increments.
     - Redirect overrides stall.
  3. stall: pc_q, state and all IF/ID fields hold.
  4. RUN, in range:
     - IF/ID={valid=1, pc=pc_q, pc_plus4=pc_q+4, instr=imem_instr, fault=0}.
     - pc_q=pc_q+4, wrapping modulo 2^32.
     - perf_fetched increments.
  5. RUN, out of range:
     - IF/ID={valid=1, pc=pc_q, pc_plus4=pc_q+4, instr=NOP, fault=1}.
     - pc_q holds; state goes to HALT.
     - perf_fetched does not increment.
  6. HALT:
     - IF/ID valid=0, instr=NOP, fault=0; pc_q holds.
     - perf_bubbles increments.
- The fault slot (step 5) is delivered exactly once. Only redirect or rst leaves HALT.
- The low two bits of pc_q are always 0.
- Arithmetic: pc_q+4 is 32-bit with no carry out. Counters are 32-bit and wrap.

## Timing
- imem_addr to imem_instr is combinational in the same cycle. The word is captured into IF/ID at the next edge, so IF/ID has 1-cycle latency from the PC.
- The first edge after rst deasserts loads the instruction at RESET_PC into IF/ID. if_id_valid=1 on the following cycle.
- Redirect seen at edge N: the bubble is in IF/ID after N; target instruction is valid in IF/ID after N+1.
- Stall held for k cycles freezes all outputs for k cycles. Fetch resumes at the first edge with stall=0.
- rst asserted mid-stream overrides stall, redirect and HALT at the same edge.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetched and perf_bubbles are live registers as specified above.
- FETCH_PERF_CNT_EN undefined:
  - Counter registers are not instantiated.
  - perf_fetched and perf_bubbles are tied to 32'h0.
  - Ports remain present, so the stage interface is stable.
  - All other behaviour is identical.

## Test plan
- Reset/sequential fetch: rst 1 cycle, RESET_PC=0, memory holds words 0x11,0x22,0x33 at addresses 0,4,8 -> IF/ID sequence (pc,instr) = (0,0x11),(4,0x22),(8,0x33); imem_addr 0,4,8,12; perf_fetched=3.
- Stall: stall=1 for 3 cycles while IF/ID holds pc=4 -> IF/ID and imem_addr=8 unchanged for 3 cycles; next edge loads pc=8.
- Redirect vs stall: stall=1 and redirect_valid=1, redirect_pc=0x43 in the same cycle -> pc_q=0x40, IF/ID valid=0/instr=0x13; next edge IF/ID pc=0x40, valid=1; perf_bubbles +1.
- Out of range: IMEM_WORDS=4, run from 0 -> slot pc=0x10 has valid=1, fault=1, instr=0x13, then valid=0 every cycle with imem_addr stuck at 0x10; redirect_pc=0 restarts with pc=0 valid.
- Reset mid-HALT with redirect asserted: rst=1 -> all outputs at reset values, pc_q=RESET_PC, state RUN.
- Build without FETCH_PERF_CNT_EN: repeat scenario 1 -> identical IF/ID trace, perf_fetched=perf_bubbles=0 throughout.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC, instruction memory address and IF/ID register; optional counters via FETCH_PERF_CNT_EN
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_fault,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    // 33 bits so a 4 GiB memory still yields a correct bound
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    logic [31:0] pc_q;
    logic [0:0]  state_q;
    logic        pc_in_range;
    logic [31:0] pc_plus4;

    assign imem_addr   = pc_q;
    assign pc_in_range = ({1'b0, pc_q} < IMEM_BYTES);
    assign pc_plus4    = pc_q + 32'd4;

    // PC, FSM and IF/ID register, prioritised rst > redirect > stall > run/halt
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= {RESET_PC[31:2], 2'b00};
            state_q        <= ST_RUN;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_instr    <= NOP;
            if_id_fault    <= 1'b0;
        end else if (redirect_valid) begin
            pc_q        <= {redirect_pc[31:2], 2'b00};
            state_q     <= ST_RUN;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
            if_id_fault <= 1'b0;
        end else if (!stall) begin
            if (state_q == ST_RUN) begin
                if_id_valid    <= 1'b1;
                if_id_pc       <= pc_q;
                if_id_pc_plus4 <= pc_plus4;
                if (pc_in_range) begin
                    if_id_instr <= imem_instr;
                    if_id_fault <= 1'b0;
                    pc_q        <= pc_plus4;
                end else begin
                    // deliver the fault slot once, then freeze
                    if_id_instr <= NOP;
                    if_id_fault <= 1'b1;
                    state_q     <= ST_HALT;
                end
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP;
                if_id_fault <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_inc;
    logic        bubble_inc;
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;

    assign fetch_inc  = !redirect_valid && !stall && (state_q == ST_RUN) && pc_in_range;
    assign bubble_inc = redirect_valid || (!stall && (state_q == ST_HALT));

    // fetched/bubble counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= 32'h0;
            bubbles_q <= 32'h0;
        end else begin
            if (fetch_inc) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (bubble_inc) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    localparam int          WORDS = 32;
    localparam logic [31:0] BYTES = 32'(WORDS * 4);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_fault;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        fault;
        logic [31:0] addr;
        logic [31:0] fetched;
        logic [31:0] bubbles;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [31:0] m_fetched;
    logic [31:0] m_bubbles;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h11;
            32'h4:   mem_word = 32'h22;
            32'h8:   mem_word = 32'h33;
            default: mem_word = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    instruction_fetch_stage #(
        .RESET_PC  (32'h0),
        .IMEM_WORDS(WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr),
        .if_id_fault   (if_id_fault),
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // drive one cycle of stimulus, push the model's prediction, compare after the edge
    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        exp_t e;
        exp_t got;
        rst = r;
        stall = s;
        redirect_valid = rv;
        redirect_pc = rpc;
        if (r) begin
            m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
            m_instr = NOP; m_fault = 1'b0; m_fetched = 32'h0; m_bubbles = 32'h0;
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00}; m_halt = 1'b0; m_valid = 1'b0; m_instr = NOP;
            m_fault = 1'b0; m_bubbles = m_bubbles + 1;
        end else if (s) begin
            m_pc = m_pc;
        end else if (!m_halt && (m_pc < BYTES)) begin
            m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem_word(m_pc);
            m_fault = 1'b0; m_pc = m_pc + 4; m_fetched = m_fetched + 1;
        end else if (!m_halt) begin
            m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = NOP;
            m_fault = 1'b1; m_halt = 1'b1;
        end else begin
            m_valid = 1'b0; m_instr = NOP; m_fault = 1'b0; m_bubbles = m_bubbles + 1;
        end
        e.valid = m_valid; e.pc = m_ipc; e.pc4 = m_ipc4; e.instr = m_instr;
        e.fault = m_fault; e.addr = m_pc;
`ifdef FETCH_PERF_CNT_EN
        e.fetched = m_fetched; e.bubbles = m_bubbles;
`else
        e.fetched = 32'h0; e.bubbles = 32'h0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("valid", {31'h0, if_id_valid}, {31'h0, got.valid});
        check("instr", if_id_instr, got.instr);
        check("fault", {31'h0, if_id_fault}, {31'h0, got.fault});
        check("imem_addr", imem_addr, got.addr);
        check("perf_fetched", perf_fetched, got.fetched);
        check("perf_bubbles", perf_bubbles, got.bubbles);
        // pc fields are don't-care while the slot is a bubble
        if (got.valid) begin
            check("pc", if_id_pc, got.pc);
            check("pc_plus4", if_id_pc_plus4, got.pc4);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);

        // reset state
        step(1, 0, 0, 0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc4", if_id_pc_plus4, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // sequential fetch up to pc=4
        step(0, 0, 0, 0);
        check("seq0_instr", if_id_instr, 32'h11);
        step(0, 0, 0, 0);
        check("seq1_pc", if_id_pc, 32'h4);
        check("seq1_instr", if_id_instr, 32'h22);

        // stall for three cycles while IF/ID holds pc=4
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("stall_pc", if_id_pc, 32'h4);
            check("stall_addr", imem_addr, 32'h8);
        end
        step(0, 0, 0, 0);
        check("resume_pc", if_id_pc, 32'h8);
        check("resume_instr", if_id_instr, 32'h33);
        check("resume_addr", imem_addr, 32'hC);

        // redirect beats stall; low bits of target dropped
        step(0, 1, 1, 32'h43);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_instr", if_id_instr, NOP);
        step(0, 0, 0, 0);
        check("redir_tgt_pc", if_id_pc, 32'h40);

        // run off the end of memory
        step(0, 0, 1, BYTES - 8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("fault_pc", if_id_pc, BYTES);
        check("fault_flag", {31'h0, if_id_fault}, 32'h1);
        check("fault_valid", {31'h0, if_id_valid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("halt_addr", imem_addr, BYTES);
            check("halt_fault", {31'h0, if_id_fault}, 32'h0);
        end
        step(0, 1, 0, 0);

        // redirect out of HALT back to 0
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        check("restart_pc", if_id_pc, 32'h0);
        check("restart_instr", if_id_instr, 32'h11);

        // top-of-address-space fault: pc_plus4 wraps to 0
        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);
        step(0, 0, 0, 0);

        // reset during HALT with redirect and stall asserted
        step(1, 1, 1, 32'h20);
        check("rst_halt_addr", imem_addr, 32'h0);
        check("rst_halt_valid", {31'h0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0);
        check("post_rst_instr", if_id_instr, 32'h11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
